// File: rtl/sr_pattern_gen.sv
// Serial pattern generator: parallel load, MSB-first one-bit stream; SR_PARITY_EN appends an even-parity bit.
// Latency: first bit is registered on out the cycle after load is sampled; done pulses one cycle after the last bit.
// Backpressure: en=0 freezes the stream in place; load is ignored while busy.
module sr_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int LEN_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic             en,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             vld_q, vld_d;
    logic             done_q, done_d;
    logic [LEN_W-1:0] len_eff;
    logic [WIDTH-1:0] aligned;
`ifdef SR_PARITY_EN
    logic             par_q, par_d;
`endif

    // Over-long requests are clamped; the left shift drops the unused upper bits,
    // so the current bit always sits at the MSB of shreg.
    assign len_eff = (len > WIDTH_L) ? WIDTH_L : len;
    assign aligned = pattern << (WIDTH_L - len_eff);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef SR_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
`ifdef SR_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        vld_d   = vld_q;
        done_d  = 1'b0;
`ifdef SR_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (load && (len != '0)) begin
                    shreg_d = aligned;
                    out_d   = aligned[WIDTH-1];
                    vld_d   = 1'b1;
                    cnt_d   = len_eff - LEN_W'(1);
                    state_d = SHIFT;
`ifdef SR_PARITY_EN
                    par_d   = ^aligned;
`endif
                end
            end
            SHIFT: begin
                if (en) begin
                    if (cnt_q != '0) begin
                        shreg_d = shreg_q << 1;
                        out_d   = shreg_q[WIDTH-2];
                        cnt_d   = cnt_q - LEN_W'(1);
                    end else begin
`ifdef SR_PARITY_EN
                        out_d   = par_q;
                        state_d = PAR;
`else
                        out_d   = 1'b0;
                        vld_d   = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
`endif
                    end
                end
            end
`ifdef SR_PARITY_EN
            PAR: begin
                if (en) begin
                    out_d   = 1'b0;
                    vld_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                out_d   = 1'b0;
                vld_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign out       = out_q;
    assign out_valid = vld_q;
    assign done      = done_q;
    assign busy      = (state_q != IDLE);

    a_out_quiet: assert property (@(posedge clk) disable iff (!reset) !out_valid |-> !out);
    a_done_idle: assert property (@(posedge clk) disable iff (!reset) done |-> !busy);

endmodule

// File: tb/tb_sr_pattern_gen.sv
// Bench for sr_pattern_gen: vector table plus hand sequences, bit stream checked against a queue.
module tb_sr_pattern_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [7:0] pattern;
    logic [3:0] len;
    logic       en;
    logic       out;
    logic       out_valid;
    logic       busy;
    logic       done;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   load_cyc = 0;
    int   dcyc;
    bit   mon_on = 1'b0;
    logic exp_q[$];

`ifdef SR_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    typedef struct {
        logic [7:0] pattern;
        logic [3:0] len;
        int         n;
        logic [7:0] bits;
    } vec_t;

    vec_t vecs[10];

    sr_pattern_gen #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .pattern   (pattern),
        .len       (len),
        .en        (en),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Every valid cycle consumes one expected bit; idle cycles must show out=0.
    always @(negedge clk) begin
        if (mon_on) begin
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_bit: got out=%b with no bit expected (cycle %0d)", out, cyc);
                end else begin
                    check("stream_bit", int'(out), int'(exp_q.pop_front()));
                end
            end else begin
                check("idle_out_zero", int'(out), 0);
            end
        end
    end

    task automatic push_frame(input vec_t v);
        logic p;
        p = 1'b0;
        for (int i = 0; i < v.n; i++) begin
            exp_q.push_back(v.bits[v.n-1-i]);
            p ^= v.bits[v.n-1-i];
        end
        if (PB == 1) exp_q.push_back(p);
    endtask

    task automatic drive_load(input logic [7:0] p, input logic [3:0] l);
        @(posedge clk);
        #1;
        load = 1'b1;
        pattern = p;
        len = l;
        @(posedge clk);
        #1;
        load_cyc = cyc;
        load = 1'b0;
    endtask

    task automatic wait_done(input string nm, output int dc);
        dc = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dc = cyc;
                break;
            end
        end
        if (dc < 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got no done pulse expected one within 40 cycles", nm);
        end
    endtask

    task automatic run_vec(input vec_t v);
        if (v.n == 0) begin
            drive_load(v.pattern, v.len);
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                check("len0_busy", int'(busy), 0);
                check("len0_done", int'(done), 0);
            end
        end else begin
            push_frame(v);
            drive_load(v.pattern, v.len);
            wait_done("frame", dcyc);
            if (dcyc >= 0) check("done_latency", dcyc - load_cyc, v.n + PB);
        end
    endtask

    initial begin
        vecs[0] = '{8'h0B, 4'd4,  4, 8'b0000_1011};
        vecs[1] = '{8'hA5, 4'd12, 8, 8'hA5};
        vecs[2] = '{8'hFF, 4'd1,  1, 8'h01};
        vecs[3] = '{8'h3C, 4'd8,  8, 8'h3C};
        vecs[4] = '{8'hF2, 4'd3,  3, 8'h02};
        vecs[5] = '{8'h81, 4'd15, 8, 8'h81};
        vecs[6] = '{8'h03, 4'd2,  2, 8'h03};
        vecs[7] = '{8'h5A, 4'd0,  0, 8'h00};
        vecs[8] = '{8'hC4, 4'd5,  5, 8'h04};
        vecs[9] = '{8'h80, 4'd8,  8, 8'h80};

        reset = 1'b0;
        load = 1'b0;
        pattern = '0;
        len = '0;
        en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out", int'(out), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        reset = 1'b1;
        mon_on = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Stall: 2nd bit held for three cycles in total.
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b1);
        if (PB == 1) exp_q.push_back(1'b1);
        drive_load(8'h0B, 4'd4);
        @(posedge clk);
        #1 en = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 en = 1'b1;
        wait_done("stall", dcyc);
        if (dcyc >= 0) check("stall_latency", dcyc - load_cyc, 6 + PB);

        // Load while busy is ignored.
        push_frame(vecs[0]);
        drive_load(8'h0B, 4'd4);
        @(posedge clk);
        #1;
        load = 1'b1;
        pattern = 8'hFF;
        len = 4'd8;
        check("busy_mid_frame", int'(busy), 1);
        @(posedge clk);
        #1 load = 1'b0;
        wait_done("busy_load", dcyc);
        if (dcyc >= 0) check("busy_load_latency", dcyc - load_cyc, 4 + PB);

        // Back-to-back: load in the done cycle leaves exactly one idle cycle.
        push_frame(vecs[0]);
        drive_load(8'h0B, 4'd4);
        wait_done("b2b_a", dcyc);
        check("b2b_done_valid", int'(out_valid), 0);
        check("b2b_done_busy", int'(busy), 0);
        push_frame(vecs[1]);
        load = 1'b1;
        pattern = 8'hA5;
        len = 4'd8;
        @(posedge clk);
        #1;
        load_cyc = cyc;
        load = 1'b0;
        @(negedge clk);
        check("b2b_first_valid", int'(out_valid), 1);
        wait_done("b2b_b", dcyc);
        if (dcyc >= 0) check("b2b_latency", dcyc - load_cyc, 8 + PB);

        // Reset mid-frame aborts without a done pulse.
        push_frame(vecs[0]);
        drive_load(8'h0B, 4'd4);
        @(posedge clk);
        @(negedge clk);
        #2;
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("abort_out", int'(out), 0);
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_busy", int'(busy), 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort_no_done", int'(done), 0);
        end
        #2 reset = 1'b1;
        run_vec(vecs[0]);

        repeat (3) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
